// File: rtl/mem_access_unit_if.sv
// Bus between the MEM pipeline stage, the memory access unit and the data memory.
// The slave side is the unit itself; the master side is the pipeline plus dmem.
interface mem_access_unit_if;
  logic        req;
  logic        we_in;
  logic [1:0]  size;
  logic        unsigned_load;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        stall;
  logic        misaligned;
  logic [7:0]  err_count;
  logic        dmem_we;
  logic [31:0] dmem_a;
  logic [31:0] dmem_wd;
  logic [31:0] dmem_rd;

  modport master (
    output req, we_in, size, unsigned_load, addr, wdata, dmem_rd,
    input  rdata, ready, stall, misaligned, err_count, dmem_we, dmem_a, dmem_wd
  );

  modport slave (
    input  req, we_in, size, unsigned_load, addr, wdata, dmem_rd,
    output rdata, ready, stall, misaligned, err_count, dmem_we, dmem_a, dmem_wd
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: single-cycle loads and word stores, two-cycle
// read-modify-write for byte/half stores, misalignment detection and counting.
module mem_access_unit (
  input  logic             clk,
  input  logic             reset,
  mem_access_unit_if.slave bus
);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t      state;
  state_t      next_state;
  logic [31:0] lat_addr;
  logic [31:0] merged;
  logic [7:0]  err_count;
  logic [31:0] aligned_addr;
  logic [31:0] merge_word;
  logic [31:0] load_word;
  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic        mis;
  logic        sub_store;

  assign aligned_addr  = {bus.addr[31:2], 2'b00};
  assign bus.err_count = err_count;

  always_comb begin
    mis = (bus.size == 2'b11) ||
          (bus.size == 2'b01 && bus.addr[0]) ||
          (bus.size == 2'b10 && bus.addr[1:0] != 2'b00);
  end

  assign sub_store = bus.req && bus.we_in && !mis && (bus.size != 2'b10);

  // Lane extraction for loads and lane replacement for the sub-word merge.
  always_comb begin
    byte_val   = bus.dmem_rd[{bus.addr[1:0], 3'b000} +: 8];
    half_val   = bus.dmem_rd[{bus.addr[1], 4'b0000} +: 16];
    load_word  = bus.dmem_rd;
    merge_word = bus.dmem_rd;
    case (bus.size)
      2'b00: begin
        load_word = bus.unsigned_load ? {24'd0, byte_val} : {{24{byte_val[7]}}, byte_val};
        merge_word[{bus.addr[1:0], 3'b000} +: 8] = bus.wdata[7:0];
      end
      2'b01: begin
        load_word = bus.unsigned_load ? {16'd0, half_val} : {{16{half_val[15]}}, half_val};
        merge_word[{bus.addr[1], 4'b0000} +: 16] = bus.wdata[15:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    next_state     = state;
    bus.dmem_we    = 1'b0;
    bus.dmem_a     = aligned_addr;
    bus.dmem_wd    = bus.wdata;
    bus.ready      = 1'b0;
    bus.stall      = 1'b0;
    bus.misaligned = 1'b0;
    bus.rdata      = 32'd0;
    if (reset) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req) begin
            if (mis) begin
              bus.misaligned = 1'b1;
              bus.ready      = 1'b1;
            end else if (!bus.we_in) begin
              bus.ready = 1'b1;
              bus.rdata = load_word;
            end else if (bus.size == 2'b10) begin
              bus.dmem_we = 1'b1;
              bus.ready   = 1'b1;
            end else begin
              bus.stall  = 1'b1;
              next_state = WRITE;
            end
          end
        end
        WRITE: begin
          bus.dmem_we = 1'b1;
          bus.dmem_a  = lat_addr;
          bus.dmem_wd = merged;
          bus.ready   = 1'b1;
          next_state  = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lat_addr  <= 32'd0;
      merged    <= 32'd0;
      err_count <= 8'd0;
    end else begin
      state <= next_state;
      if (state == IDLE && bus.req && mis && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
      if (state == IDLE && sub_store) begin
        lat_addr <= aligned_addr;
        merged   <= merge_word;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed scenarios followed by random traffic
// checked against a byte-addressed reference memory model.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   model_err = 0;
  logic [31:0] obs_rdata;
  logic [31:0] rnd_addr;
  logic [31:0] rnd_wd;
  logic [1:0]  rnd_sz;
  logic        rnd_we;
  logic        rnd_uns;

  always #5 clk = ~clk;

  mem_access_unit_if bus();

  mem_access_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Data memory: combinational read, write on rising edge.
  logic [31:0] dmem [256] = '{default: 32'd0};
  assign bus.dmem_rd = dmem[bus.dmem_a[9:2]];
  always @(posedge clk) if (bus.dmem_we) dmem[bus.dmem_a[9:2]] <= bus.dmem_wd;

  // Reference model: the memory as a flat array of bytes.
  logic [7:0] ref_mem [1024] = '{default: 8'd0};

  function automatic logic is_mis(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int b;
    b = int'(a[9:2]) * 4;
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns, input logic [31:0] a);
    int b;
    logic [15:0] h;
    b = int'(a[9:0]);
    case (sz)
      2'b00:   return uns ? {24'd0, ref_mem[b]} : {{24{ref_mem[b][7]}}, ref_mem[b]};
      2'b01: begin
        h = {ref_mem[b+1], ref_mem[b]};
        return uns ? {16'd0, h} : {{16{h[15]}}, h};
      end
      default: return ref_word(a);
    endcase
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int b;
    int n;
    b = int'(a[9:0]);
    n = 1 << sz;
    for (int k = 0; k < n; k++) ref_mem[b+k] = wd[8*k +: 8];
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete operation, entered and left at 1 time unit after a rising edge.
  task automatic apply_stimulus(input logic we, input logic [1:0] sz, input logic uns,
                                input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] exp_wd;
    check_output("err_count", {24'd0, bus.err_count}, 32'(model_err));
    bus.req = 1'b1; bus.we_in = we; bus.size = sz; bus.unsigned_load = uns;
    bus.addr = a; bus.wdata = wd;
    #1;
    obs_rdata = bus.rdata;
    if (is_mis(sz, a)) begin
      check_output("mis_flag", 32'(bus.misaligned), 32'd1);
      check_output("mis_ready", 32'(bus.ready), 32'd1);
      check_output("mis_stall", 32'(bus.stall), 32'd0);
      check_output("mis_we", 32'(bus.dmem_we), 32'd0);
      check_output("mis_rdata", bus.rdata, 32'd0);
      @(posedge clk);
      model_err = (model_err == 255) ? 255 : model_err + 1;
    end else if (!we) begin
      check_output("ld_mis", 32'(bus.misaligned), 32'd0);
      check_output("ld_ready", 32'(bus.ready), 32'd1);
      check_output("ld_stall", 32'(bus.stall), 32'd0);
      check_output("ld_we", 32'(bus.dmem_we), 32'd0);
      check_output("ld_rdata", bus.rdata, ref_load(sz, uns, a));
      @(posedge clk);
    end else if (sz == 2'b10) begin
      check_output("sw_ready", 32'(bus.ready), 32'd1);
      check_output("sw_stall", 32'(bus.stall), 32'd0);
      check_output("sw_we", 32'(bus.dmem_we), 32'd1);
      check_output("sw_addr", bus.dmem_a, {a[31:2], 2'b00});
      check_output("sw_wd", bus.dmem_wd, wd);
      @(posedge clk);
      ref_store(sz, a, wd);
    end else begin
      check_output("sub_stall", 32'(bus.stall), 32'd1);
      check_output("sub_ready1", 32'(bus.ready), 32'd0);
      check_output("sub_we1", 32'(bus.dmem_we), 32'd0);
      ref_store(sz, a, wd);
      exp_wd = ref_word(a);
      @(posedge clk);
      #1;
      bus.we_in = 1'($urandom_range(0, 1));
      bus.size  = 2'($urandom_range(0, 3));
      bus.addr  = 32'($urandom_range(0, 1023));
      bus.wdata = $urandom;
      #1;
      check_output("sub_we2", 32'(bus.dmem_we), 32'd1);
      check_output("sub_ready2", 32'(bus.ready), 32'd1);
      check_output("sub_stall2", 32'(bus.stall), 32'd0);
      check_output("sub_addr", bus.dmem_a, {a[31:2], 2'b00});
      check_output("sub_wd", bus.dmem_wd, exp_wd);
      @(posedge clk);
    end
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.req = 1'b1; bus.we_in = 1'b1; bus.size = 2'b10; bus.unsigned_load = 1'b0;
    bus.addr = 32'h0; bus.wdata = 32'h12345678;
    @(posedge clk); #1;
    check_output("rst_we", 32'(bus.dmem_we), 32'd0);
    check_output("rst_ready", 32'(bus.ready), 32'd0);
    check_output("rst_stall", 32'(bus.stall), 32'd0);
    check_output("rst_mis", 32'(bus.misaligned), 32'd0);
    check_output("rst_rdata", bus.rdata, 32'd0);
    check_output("rst_err", {24'd0, bus.err_count}, 32'd0);
    reset = 1'b0;
    bus.req = 1'b0;
    #1;
    check_output("idle_ready", 32'(bus.ready), 32'd0);
    @(posedge clk); #1;

    $display("[TB] word store / load");
    apply_stimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    apply_stimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check_output("dir_word", obs_rdata, 32'hDEADBEEF);

    $display("[TB] byte store merge");
    apply_stimulus(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AA);
    apply_stimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check_output("dir_merge", obs_rdata, 32'hDEADAAEF);

    $display("[TB] sub-word loads");
    apply_stimulus(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    check_output("dir_lb", obs_rdata, 32'hFFFFFFAA);
    apply_stimulus(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
    check_output("dir_lbu", obs_rdata, 32'h000000AA);
    apply_stimulus(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    check_output("dir_lh", obs_rdata, 32'hFFFFDEAD);

    $display("[TB] misaligned accesses");
    apply_stimulus(1'b0, 2'b10, 1'b0, 32'h02, 32'h0);
    apply_stimulus(1'b0, 2'b01, 1'b0, 32'h03, 32'h0);
    apply_stimulus(1'b0, 2'b11, 1'b0, 32'h00, 32'h0);
    check_output("dir_err3", {24'd0, bus.err_count}, 32'd3);
    for (int i = 0; i < 297; i++) apply_stimulus(1'b1, 2'b11, 1'b0, 32'h40, 32'h0);
    check_output("dir_err_sat", {24'd0, bus.err_count}, 32'd255);

    $display("[TB] reset aborts pending half store");
    bus.req = 1'b1; bus.we_in = 1'b1; bus.size = 2'b01; bus.unsigned_load = 1'b0;
    bus.addr = 32'h20; bus.wdata = 32'h00001234;
    #1;
    check_output("abort_stall", 32'(bus.stall), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check_output("abort_we", 32'(bus.dmem_we), 32'd0);
    check_output("abort_ready", 32'(bus.ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.req = 1'b0;
    model_err = 0;
    apply_stimulus(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    check_output("abort_word", obs_rdata, 32'h0);
    check_output("abort_err", {24'd0, bus.err_count}, 32'd0);

    $display("[TB] word fill and readback");
    for (int i = 0; i < 64; i++) apply_stimulus(1'b1, 2'b10, 1'b0, 32'(i * 4), 32'(i));
    for (int i = 0; i < 64; i++) begin
      apply_stimulus(1'b0, 2'b10, 1'b0, 32'(i * 4), 32'h0);
      check_output("fill_rd", obs_rdata, 32'(i));
    end

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      rnd_we   = 1'($urandom_range(0, 1));
      rnd_sz   = 2'($urandom_range(0, 3));
      rnd_uns  = 1'($urandom_range(0, 1));
      rnd_addr = 32'($urandom_range(0, 1023));
      rnd_wd   = $urandom;
      apply_stimulus(rnd_we, rnd_sz, rnd_uns, rnd_addr, rnd_wd);
    end
    check_output("final_err", {24'd0, bus.err_count}, 32'(model_err));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The unit SHALL have a single clock; reset is synchronous and active-high.
REQ-002 CLK  in  1  clock; all state updates on the rising edge.
REQ-003 RESET  in  1  synchronous, active-high reset.
REQ-004 REQ  in  1  MEM-stage memory operation valid.
REQ-005 WE_IN  in  1  1 = store, 0 = load.
REQ-006 SIZE  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-007 UNSIGNED  in  1  1 = zero-extend load, 0 = sign-extend.
REQ-008 ADDR  in  32  byte address.
REQ-009 WDATA  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 RDATA  out  32  extended load result.
REQ-011 READY  out  1  operation completes this cycle.
REQ-012 STALL  out  1  pipeline SHALL hold MEM-stage inputs stable.
REQ-013 MISALIGNED  out  1  illegal/misaligned access this cycle.
REQ-014 ERR_COUNT  out  8  saturating count of misaligned requests.
REQ-015 DMEM_WE, DMEM_A, DMEM_WD  out  1/32/32  to dmem WE, A, WD.
REQ-016 DMEM_RD  in  32  from dmem RD (combinational read of word at A; write on rising CLK when WE=1).

Function
REQ-017 DMEM_A SHALL be {ADDR[31:2],2'b00} in IDLE and the latched aligned address in WRITE.
REQ-018 FSM states SHALL be IDLE and WRITE only.
REQ-019 Misaligned: SIZE=11, SIZE=01 with ADDR[0]=1, or SIZE=10 with ADDR[1:0]!=0.
REQ-020 IDLE, REQ=0: DMEM_WE=0, READY=0, STALL=0, MISALIGNED=0, RDATA=0; stay IDLE.
REQ-021 IDLE, REQ=1, misaligned: MISALIGNED=1, READY=1, STALL=0, DMEM_WE=0, RDATA=0; ERR_COUNT+1 at edge, saturating at 255; stay IDLE.
REQ-022 IDLE, aligned load: same-cycle READY=1; lane k=ADDR[1:0] (little-endian, byte k = DMEM_RD[8k+7:8k]; half uses ADDR[1]); result sign- or zero-extended per UNSIGNED; word returned unchanged.
REQ-023 IDLE, aligned word store: DMEM_WE=1, DMEM_WD=WDATA, READY=1, STALL=0; stay IDLE.
REQ-024 IDLE, aligned byte/half store: DMEM_WE=0, STALL=1, READY=0; at edge latch aligned address and merged word (DMEM_RD with selected lanes replaced by WDATA low bits); go WRITE.
REQ-025 WRITE: DMEM_WE=1, DMEM_WD=merged word, READY=1, STALL=0; inputs ignored; next state IDLE unconditionally.
REQ-026 Sub-word store latency SHALL be 2 cycles; all other operations 1 cycle.
REQ-027 Load from a word stored the previous cycle SHALL return the new data (dmem write-then-read).

Reset
REQ-028 While RESET=1: DMEM_WE=0, READY=0, STALL=0, MISALIGNED=0, RDATA=0 regardless of REQ.
REQ-029 At reset edge: state=IDLE, latched address=0, merged word=0, ERR_COUNT=0.
REQ-030 RESET asserted in WRITE SHALL abort the store: no dmem write occurs; next state IDLE.

Verification
REQ-031 Word store 0xDEADBEEF @0x10, then word load @0x10 -> RDATA=0xDEADBEEF, READY=1 each cycle, STALL=0.
REQ-032 Byte store 0x000000AA @0x11 over 0xDEADBEEF -> STALL=1 one cycle, then DMEM_WE=1, DMEM_WD=0xDEADAAEF; word load -> 0xDEADAAEF.
REQ-033 Byte load @0x11 from 0xDEADAAEF: UNSIGNED=0 -> 0xFFFFFFAA; UNSIGNED=1 -> 0x000000AA; half load @0x12 signed -> 0xFFFFDEAD.
REQ-034 Word load @0x02, half load @0x03, SIZE=11 @0x00 -> MISALIGNED=1, DMEM_WE=0 each; ERR_COUNT=3; 300 misaligned requests -> ERR_COUNT=255.
REQ-035 Half store 0x1234 @0x20 with RESET=1 during WRITE cycle -> no write; word @0x20 unchanged; ERR_COUNT=0; state IDLE.
REQ-036 Word store i to addresses 0..252 step 4, then read back -> RDATA=i at each address.
